// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared significand widths and sequencer state encoding
package sig_pkg;

    localparam int NSIG_DEF = 10;
    localparam int SIGW     = NSIG_DEF + 1;
    localparam int QW       = NSIG_DEF + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sigdiv_if.sv
// rtl/sigdiv_if.sv - operand/result handshake bundle for the significand divider
interface sigdiv_if
    import sig_pkg::*;
#(
    parameter int NSIG = NSIG_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [NSIG:0]     a;
    logic [NSIG:0]     b;
    logic              out_valid;
    logic              out_ready;
    logic [NSIG+1:0]   q;
    logic              sticky;
    logic              dz;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, sticky, dz
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, sticky, dz
    );
endinterface

// File: rtl/sigdiv_step.sv
// rtl/sigdiv_step.sv - one restoring-division iteration: compare, subtract, shift
module sigdiv_step #(
    parameter int W = 12
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] div,
    output logic         q_bit,
    output logic [W-1:0] rem_next
);
    logic [W-1:0] diff;

    // rem < 2*div keeps the shifted result inside W bits
    always_comb begin
        diff     = rem - div;
        q_bit    = (rem >= div);
        rem_next = q_bit ? {diff[W-2:0], 1'b0} : {rem[W-2:0], 1'b0};
    end
endmodule

// File: rtl/sigdiv.sv
// rtl/sigdiv.sv - iterative restoring significand divider, one quotient bit per clock
module sigdiv
    import sig_pkg::*;
#(
    parameter int NSIG = NSIG_DEF
) (
    input  logic     clk,
    input  logic     rst,
    sigdiv_if.slave  bus
);
    localparam int SW  = NSIG + 1;
    localparam int QWL = NSIG + 2;
    localparam int CW  = $clog2(QWL + 1);

    state_t           state_q, state_d;
    logic [QWL-1:0]   rem_q, rem_d;
    logic [QWL-1:0]   q_q, q_d;
    logic [SW-1:0]    div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             dz_q, dz_d;
    logic             step_bit;
    logic [QWL-1:0]   step_rem;

    sigdiv_step #(.W(QWL)) u_step (
        .rem      (rem_q),
        .div      ({1'b0, div_q}),
        .q_bit    (step_bit),
        .rem_next (step_rem)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        q_d      = q_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rem_d    = {1'b0, bus.a};
                    div_d    = bus.b;
                    q_d      = '0;
                    cnt_d    = CW'(QWL);
                    dz_d     = (bus.b == '0);
                    sticky_d = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                q_d   = {q_q[QWL-2:0], step_bit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    sticky_d = !dz_q && (step_rem != '0);
                    // divide-by-zero still runs full length so latency stays fixed
                    if (dz_q) q_d = '1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            q_q      <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            q_q      <= q_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.q         = q_q;
    assign bus.sticky    = sticky_q;
    assign bus.dz        = dz_q;
endmodule

// File: tb/tb_sigdiv.sv
// tb/tb_sigdiv.sv - randomized self-checking bench for sigdiv against an arithmetic model
module tb_sigdiv;
    localparam int NSIG = 10;
    localparam int QWL  = NSIG + 2;
    localparam int LAT  = NSIG + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sigdiv_if #(.NSIG(NSIG)) bus ();

    sigdiv #(.NSIG(NSIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_q(input longint a, input longint b);
        if (b == 0) return (64'd1 << QWL) - 1;
        return 64'((a << (NSIG + 1)) / b);
    endfunction

    function automatic logic model_sticky(input longint a, input longint b);
        if (b == 0) return 1'b0;
        return ((a << (NSIG + 1)) % b) != 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and check latency, outputs, hold behaviour and handoff.
    task automatic run_div(input int a, input int b, input int hold, input string tag);
        int lat;
        logic [63:0] eq;
        logic        es, ed;
        eq = model_q(a, b);
        es = model_sticky(a, b);
        ed = (b == 0);
        check_eq({tag, " in_ready idle"}, bus.in_ready, 1);
        bus.a        = a[NSIG:0];
        bus.b        = b[NSIG:0];
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check_eq({tag, " latency"}, lat, LAT);
        check_eq({tag, " q"}, bus.q, eq);
        check_eq({tag, " sticky"}, bus.sticky, es);
        check_eq({tag, " dz"}, bus.dz, ed);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            tick();
            check_eq({tag, " hold out_valid"}, bus.out_valid, 1);
            check_eq({tag, " hold in_ready"}, bus.in_ready, 0);
            check_eq({tag, " hold q"}, bus.q, eq);
            check_eq({tag, " hold sticky"}, bus.sticky, es);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, " handoff out_valid"}, bus.out_valid, 0);
        check_eq({tag, " handoff in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        int a, b, saw;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst           = 1'b1;
        tick();
        tick();
        check_eq("reset in_ready", bus.in_ready, 1);
        check_eq("reset out_valid", bus.out_valid, 0);
        check_eq("reset q", bus.q, 0);
        check_eq("reset sticky", bus.sticky, 0);
        check_eq("reset dz", bus.dz, 0);
        rst = 1'b0;
        tick();

        run_div('h400, 'h400, 0, "one");
        run_div('h7FF, 'h400, 0, "max_over_min");
        run_div('h400, 'h600, 0, "third");
        run_div('h400, 'h7FF, 5, "hold5");
        run_div('h5A3, 0, 1, "div_zero");

        // reset during RUN step 6 discards the operation
        bus.a        = 'h7FF;
        bus.b        = 'h401;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int s = 0; s < 6; s++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrun in_ready", bus.in_ready, 1);
        check_eq("midrun out_valid", bus.out_valid, 0);
        check_eq("midrun q", bus.q, 0);
        saw = 0;
        for (int s = 0; s < LAT + 4; s++) begin
            tick();
            if (bus.out_valid) saw = 1;
        end
        check_eq("midrun no out_valid", saw, 0);
        run_div('h400, 'h400, 0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = $urandom_range(1, 'h3FF);
                default: b = $urandom_range('h400, 'h7FF);
            endcase
            if ($urandom_range(0, 5) == 0) a = $urandom_range(1, 'h7FF);
            else                           a = $urandom_range('h400, 'h7FF);
            // unnormalized divisor could overflow a QW-bit quotient; keep within the floor range
            if (b != 0 && ((longint'(a) << (NSIG + 1)) / b) >= (longint'(1) << QWL))
                b = $urandom_range('h400, 'h7FF);
            run_div(a, b, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
